// File: rtl/acc_drain.sv
// acc_drain: snapshots the accumulator result registers when full and
// streams them one entry per beat, then pulses a clear request.
// Optional checksum beat: define ACC_DRAIN_CHECKSUM_EN.
module acc_drain #(
    parameter int NUM_ENTRIES = 2,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              acc_full,
    input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] acc_data,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              acc_clear,
    output logic                              busy
);

    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] STREAM  = 2'd2;
    localparam logic [1:0] CLEAR   = 2'd3;

    logic [1:0]                        state;
    logic                              armed;
    logic [IW-1:0]                     index;
    logic [NUM_ENTRIES*DATA_WIDTH-1:0] snap;
    logic                              xfer;
    logic                              at_last;
    logic                              done;
    logic [DATA_WIDTH-1:0]             entry;

    assign out_valid = (state == STREAM);
    assign acc_clear = (state == CLEAR);
    assign busy      = (state != IDLE);
    assign xfer      = out_valid & out_ready;
    assign at_last   = (index == LAST_IDX);
    assign entry     = snap[index*DATA_WIDTH +: DATA_WIDTH];

`ifdef ACC_DRAIN_CHECKSUM_EN
    logic                  csum_beat;
    logic [DATA_WIDTH-1:0] csum;

    // Modular sum of the frozen snapshot, sent as the trailing beat
    always_comb begin
        csum = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            csum = csum + snap[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Tracks whether the data beats are finished and the checksum is up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_beat <= 1'b0;
        end else if (state == CAPTURE) begin
            csum_beat <= 1'b0;
        end else if (xfer && at_last && !csum_beat) begin
            csum_beat <= 1'b1;
        end
    end

    assign done     = xfer & csum_beat;
    assign out_last = out_valid & csum_beat;
    assign out_data = !out_valid ? '0 : (csum_beat ? csum : entry);
`else
    assign done     = xfer & at_last;
    assign out_last = out_valid & at_last;
    assign out_data = out_valid ? entry : '0;
`endif

    // Drain sequencer: wait for full, capture, stream, request clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (acc_full && armed) state <= CAPTURE;
                CAPTURE: state <= STREAM;
                STREAM:  if (done) state <= CLEAR;
                CLEAR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A still-high full flag must drop once in IDLE before another drain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b1;
        end else if (state == IDLE && !acc_full) begin
            armed <= 1'b1;
        end else if (state == CAPTURE) begin
            armed <= 1'b0;
        end
    end

    // Snapshot at the end of CAPTURE, then walk the entries on handshakes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap  <= '0;
            index <= '0;
        end else if (state == CAPTURE) begin
            snap  <= acc_data;
            index <= '0;
        end else if (xfer && !at_last) begin
            index <= index + 1'b1;
        end
    end

endmodule
